fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Instruction-supply end of the control decoder interface: owns the PC, reads 9-bit words from
//  instruction memory, presents Instruction[8:4] as opcode to the decoder, then consumes the decoder's
//  jump_en/immOrLUT to choose the next PC (PC+1, PC-relative, or branch-LUT target).
//  Holds a loadable branch-target LUT. Runs Start -> program end -> Done.
// PARAMETERS
//  PC_W      10         PC / instruction-memory address width
//  INSTR_W   9          instruction width; [8:4] opcode, [3:0] operand
//  LUT_AW    4          branch LUT index width (2**LUT_AW entries of PC_W bits)
//  HALT_WORD 9'h000     instruction word that ends the program (all-zero NOP word)
// PORTS
//  Clk          in   1        clock, rising edge
//  Reset        in   1        asynchronous, active-low reset
//  Start        in   1        1-cycle pulse: begin at PC=0 (honoured in IDLE/DONE only)
//  Stall        in   1        hold PC and state while high (back-end busy)
//  imem_data    in   INSTR_W  read data, valid the cycle after imem_rd_en
//  jump_en      in   1        decoder: take branch for current instruction
//  immOrLUT     in   1        decoder: 1 = target from LUT[operand], 0 = PC-relative
//  lut_we       in   1        LUT write strobe (accepted in IDLE/DONE only)
//  lut_addr     in   LUT_AW   LUT write index
//  lut_data     in   PC_W     LUT write data
//  imem_addr    out  PC_W     instruction-memory address (= PC)
//  imem_rd_en   out  1        read request
//  Instruction  out  INSTR_W  current instruction, held between valid cycles
//  instr_valid  out  1        Instruction is new and decoder outputs are sampled this cycle
//  PC           out  PC_W     current PC
//  Done         out  1        program complete; held until next Start
// BEHAVIOUR
//  Reset (async, Reset==0): state=IDLE, PC=0, Instruction=0, instr_valid=0, imem_rd_en=0,
//   Done=0, all LUT entries=0. Reset mid-program aborts instantly; no partial write survives.
//  States: IDLE -> (Start) ISSUE -> WAIT -> VALID -> ISSUE ... ; VALID -> DONE on HALT_WORD.
//  ISSUE: imem_rd_en=1, imem_addr=PC. Next: WAIT.
//  WAIT: capture imem_data into Instruction at clock end. Next: VALID.
//  VALID: instr_valid=1 for exactly one cycle (unless Stall); decoder inputs sampled here.
//   Next PC: jump_en=0 -> PC+1; jump_en=1,immOrLUT=1 -> LUT[Instruction[3:0]];
//   jump_en=1,immOrLUT=0 -> PC + sign-extended Instruction[3:0] (range -8..+7).
//   All PC arithmetic modulo 2**PC_W (wrap 2**PC_W-1 -> 0, 0 - 1 -> 2**PC_W-1).
//   If Instruction==HALT_WORD: PC unchanged, state DONE, Done=1 next cycle; jump_en ignored.
//  Latency: 3 cycles per instruction unstalled (ISSUE, WAIT, VALID); first instr_valid 3 cycles after Start.
//  Stall: freezes state/PC/Instruction; in VALID instr_valid stays 1 but PC updates only on the
//   first cycle with Stall=0; in ISSUE imem_rd_en deasserts and re-issues when released.
//   Stall in WAIT: data captured normally, hold in VALID.
//  DONE: Done=1, imem_rd_en=0. Start -> PC=0, Done=0, state ISSUE. Start ignored while running.
//  LUT: write on lut_we in IDLE/DONE; read combinational; write+Start same cycle: write
//   lands, program sees new value.
// TESTING
//  Reset low mid-WAIT -> all outputs 0 asynchronously, state IDLE, LUT cleared.
//  Start, imem 0:9'h1A3,1:9'h0C1,2:HALT, jump_en=0 -> instr_valid at cycles 3,6,9; PC 0,1,2; Done at 10.
//  PC=5 word 9'h03E (operand -2), jump_en=1,immOrLUT=0 -> next imem_addr=3; PC=0 operand -1 -> 1023.
//  LUT[4]=10'h2F0 loaded in IDLE; word 9'h014 with jump_en=1,immOrLUT=1 -> next imem_addr=10'h2F0.
//  Stall high 4 cycles during VALID at PC=7 -> instr_valid held, PC stays 7, then PC=8 single step.
//  Start while in VALID -> ignored; Start in DONE -> Done drops, PC=0, refetch.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the program counter and fetches instruction words.
// It presents each word to the decoder for one VALID cycle. It then picks the
// next PC from the decoder's jump_en/immOrLUT: PC+1, PC-relative, or the
// branch-LUT target. A loadable branch-target LUT sits alongside. The program
// runs from Start until the halt word is reached.
module fetch_sequencer #(
  parameter int                 PC_W      = 10,
  parameter int                 INSTR_W   = 9,
  parameter int                 LUT_AW    = 4,
  parameter logic [INSTR_W-1:0] HALT_WORD = 9'h000
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Stall,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               jump_en,
  input  logic               immOrLUT,
  input  logic               lut_we,
  input  logic [LUT_AW-1:0]  lut_addr,
  input  logic [PC_W-1:0]    lut_data,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_rd_en,
  output logic [INSTR_W-1:0] Instruction,
  output logic               instr_valid,
  output logic [PC_W-1:0]    PC,
  output logic               Done
);

  localparam int OPND_W    = 4;
  localparam int LUT_DEPTH = 1 << LUT_AW;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_VALID = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t             state_r, state_s;
  logic [PC_W-1:0]    pc_r, pc_s;
  logic [INSTR_W-1:0] instr_r, instr_s;
  logic [PC_W-1:0]    lut_r [LUT_DEPTH];
  logic               lut_wr_s;
  logic [PC_W-1:0]    rel_target_s;
  logic [PC_W-1:0]    lut_target_s;
  logic               idle_like_s;

  // The LUT may only change while no program is running.
  assign idle_like_s  = (state_r == ST_IDLE) || (state_r == ST_DONE);
  assign lut_wr_s     = lut_we && idle_like_s;

  // The 4-bit operand is sign-extended; the PC-width add wraps modulo 2**PC_W.
  assign rel_target_s = pc_r + {{(PC_W-OPND_W){instr_r[OPND_W-1]}}, instr_r[OPND_W-1:0]};
  assign lut_target_s = lut_r[instr_r[LUT_AW-1:0]];

  // State, PC and instruction registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r <= ST_IDLE;
      pc_r    <= '0;
      instr_r <= '0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      instr_r <= instr_s;
    end
  end

  // Branch-target LUT storage, cleared by reset
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        lut_r[i] <= '0;
      end
    end else if (lut_wr_s) begin
      lut_r[lut_addr] <= lut_data;
    end else begin
      lut_r <= lut_r;
    end
  end

  // Next-state, next-PC and instruction capture
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    instr_s = instr_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          state_s = ST_ISSUE;
          pc_s    = '0;
        end else begin
          state_s = state_r;
        end
      end
      ST_ISSUE: begin
        if (!Stall) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        // Memory data is only valid now, so capture it even when stalled;
        // the stall is then absorbed in VALID.
        instr_s = imem_data;
        state_s = ST_VALID;
      end
      ST_VALID: begin
        if (Stall) begin
          state_s = ST_VALID;
        end else if (instr_r == HALT_WORD) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_ISSUE;
          if (!jump_en) begin
            pc_s = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
          end else if (immOrLUT) begin
            pc_s = lut_target_s;
          end else begin
            pc_s = rel_target_s;
          end
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  assign imem_addr   = pc_r;
  assign PC          = pc_r;
  assign Instruction = instr_r;
  assign imem_rd_en  = (state_r == ST_ISSUE) && !Stall;
  assign instr_valid = (state_r == ST_VALID);
  assign Done        = (state_r == ST_DONE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a one-cycle-latency instruction memory model.
module tb_fetch_sequencer;

  logic       Clk = 1'b0;
  logic       Reset, Start, Stall, jump_en, immOrLUT, lut_we;
  logic [3:0] lut_addr;
  logic [9:0] lut_data;
  logic [8:0] imem_data = 9'h000;
  logic [9:0] imem_addr, PC;
  logic       imem_rd_en, instr_valid, Done;
  logic [8:0] Instruction;
  logic [8:0] mem [1024];

  int checks   = 0;
  int failures = 0;

  fetch_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall),
    .imem_data(imem_data), .jump_en(jump_en), .immOrLUT(immOrLUT),
    .lut_we(lut_we), .lut_addr(lut_addr), .lut_data(lut_data),
    .imem_addr(imem_addr), .imem_rd_en(imem_rd_en), .Instruction(Instruction),
    .instr_valid(instr_valid), .PC(PC), .Done(Done)
  );

  always #5 Clk = ~Clk;

  // Instruction memory: data appears the cycle after the read request
  always @(posedge Clk) begin
    if (imem_rd_en) imem_data <= mem[imem_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!instr_valid && n < 20) begin
      step();
      n++;
    end
    if (!instr_valid) check_eq("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic lut_write(input logic [3:0] a, input logic [9:0] d);
    lut_we = 1'b1; lut_addr = a; lut_data = d;
    step();
    lut_we = 1'b0;
  endtask

  // Walk a program: expected PC at each VALID and the decoder response to give there
  task automatic run_table(input string tag, input int n, input logic [9:0] pcs [10],
                           input logic jmp [10], input logic imm [10]);
    for (int k = 0; k < n; k++) begin
      wait_valid();
      check_eq({tag, "_pc"}, 32'(PC), 32'(pcs[k]));
      jump_en = jmp[k]; immOrLUT = imm[k];
      step();
      jump_en = 1'b0; immOrLUT = 1'b0;
    end
  endtask

  logic [9:0] pcs [10];
  logic       jmp [10];
  logic       imm [10];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 9'h000;
    Reset = 1'b0; Start = 1'b0; Stall = 1'b0; jump_en = 1'b0; immOrLUT = 1'b0;
    lut_we = 1'b0; lut_addr = 4'h0; lut_data = 10'h000;
    step(); step();
    Reset = 1'b1;
    step();

    // Reset state
    check_eq("rst_pc", 32'(PC), 32'h0);
    check_eq("rst_instr", 32'(Instruction), 32'h0);
    check_eq("rst_valid", 32'(instr_valid), 32'h0);
    check_eq("rst_rden", 32'(imem_rd_en), 32'h0);
    check_eq("rst_done", 32'(Done), 32'h0);

    // Sequential program; Start during VALID must be ignored
    lut_write(4'd3, 10'h155);
    mem[0] = 9'h1A3; mem[1] = 9'h0C1; mem[2] = 9'h000;
    Start = 1'b1; step(); Start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      check_eq("seq_valid", 32'(instr_valid), 32'((c == 3) || (c == 6) || (c == 9)));
      check_eq("seq_done", 32'(Done), 32'(c == 10));
      if (c == 1) begin
        check_eq("seq_rden", 32'(imem_rd_en), 32'h1);
        check_eq("seq_addr0", 32'(imem_addr), 32'h0);
      end
      if (c == 3) begin
        check_eq("seq_pc0", 32'(PC), 32'h0);
        check_eq("seq_i0", 32'(Instruction), 32'h1A3);
        Start = 1'b1;
      end
      if (c == 6) begin
        check_eq("seq_pc1", 32'(PC), 32'h1);
        check_eq("seq_i1", 32'(Instruction), 32'h0C1);
      end
      if (c == 9) begin
        check_eq("seq_pc2", 32'(PC), 32'h2);
        check_eq("seq_i2", 32'(Instruction), 32'h000);
      end
      if (c < 10) step();
      Start = 1'b0;
    end

    // Start from DONE restarts at PC 0
    Start = 1'b1; step(); Start = 1'b0;
    check_eq("restart_done", 32'(Done), 32'h0);
    check_eq("restart_pc", 32'(PC), 32'h0);
    check_eq("restart_rden", 32'(imem_rd_en), 32'h1);
    step(); step(); step(); step();
    check_eq("pre_rst_pc", 32'(PC), 32'h1);
    check_eq("pre_rst_instr", 32'(Instruction), 32'h1A3);

    // Asynchronous reset in the middle of WAIT
    Reset = 1'b0;
    #1;
    check_eq("arst_pc", 32'(PC), 32'h0);
    check_eq("arst_addr", 32'(imem_addr), 32'h0);
    check_eq("arst_instr", 32'(Instruction), 32'h0);
    check_eq("arst_rden", 32'(imem_rd_en), 32'h0);
    check_eq("arst_valid", 32'(instr_valid), 32'h0);
    check_eq("arst_done", 32'(Done), 32'h0);
    step();
    Reset = 1'b1;
    step();

    // PC-relative jumps, cleared LUT, wrap below zero, halt at top address
    mem[0] = 9'h10F; mem[1] = 9'h101; mem[2] = 9'h102; mem[3] = 9'h103;
    mem[4] = 9'h104; mem[5] = 9'h03E; mem[1023] = 9'h000;
    pcs = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd3, 10'd0, 10'd1023, 10'd0};
    jmp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    imm = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    Start = 1'b1; step(); Start = 1'b0;
    run_table("rel", 9, pcs, jmp, imm);
    check_eq("rel_done", 32'(Done), 32'h1);
    check_eq("rel_halt_pc", 32'(PC), 32'h3FF);

    // LUT jumps: load in IDLE, write together with Start, write while running is dropped
    Reset = 1'b0; step(); Reset = 1'b1; step();
    lut_write(4'd4, 10'h2F0);
    mem[0] = 9'h014; mem[10'h2F0] = 9'h015; mem[10'h3A0] = 9'h000;
    lut_we = 1'b1; lut_addr = 4'd5; lut_data = 10'h3A0; Start = 1'b1;
    step();
    Start = 1'b0;
    lut_addr = 4'd5; lut_data = 10'h111;
    step();
    lut_we = 1'b0;
    pcs = '{10'h000, 10'h2F0, 10'h3A0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0};
    jmp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    imm = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    run_table("lut", 3, pcs, jmp, imm);
    check_eq("lut_done", 32'(Done), 32'h1);

    // Stall in VALID at PC 7, then stall in ISSUE at PC 8
    for (int i = 0; i < 7; i++) mem[i] = 9'h100 + 9'(i);
    mem[7] = 9'h1F7; mem[8] = 9'h000;
    Start = 1'b1; step(); Start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      wait_valid();
      step();
    end
    wait_valid();
    check_eq("stl_pc7", 32'(PC), 32'h7);
    Stall = 1'b1;
    for (int s = 0; s < 4; s++) begin
      step();
      check_eq("stl_valid_hold", 32'(instr_valid), 32'h1);
      check_eq("stl_pc_hold", 32'(PC), 32'h7);
    end
    Stall = 1'b0;
    step();
    check_eq("stl_pc8", 32'(PC), 32'h8);
    check_eq("stl_valid_drop", 32'(instr_valid), 32'h0);
    check_eq("stl_issue_rden", 32'(imem_rd_en), 32'h1);
    Stall = 1'b1;
    #1;
    check_eq("stl_issue_gate", 32'(imem_rd_en), 32'h0);
    step();
    check_eq("stl_issue_hold", 32'(imem_rd_en), 32'h0);
    check_eq("stl_issue_addr", 32'(imem_addr), 32'h8);
    Stall = 1'b0;
    #1;
    check_eq("stl_reissue", 32'(imem_rd_en), 32'h1);
    step();
    wait_valid();
    check_eq("stl_halt_instr", 32'(Instruction), 32'h000);
    step();
    check_eq("stl_done", 32'(Done), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
